cursor_brush_ctrl: RTL

CURSOR_BRUSH_CTRL -- requirements
Module: cursor_brush_ctrl

---
 rtl/cursor_pkg.sv | 17 +
 rtl/cursor_brush_ctrl_btn_repeat.sv | 44 ++++
 rtl/cursor_brush_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cursor_pkg.sv
// Shared types and default geometry for the cursor/brush controller.
package cursor_pkg;

  typedef enum logic {
    IDLE,
    STAMP
  } stamp_state_t;

  typedef logic [11:0] colour_t;

  localparam int DEF_WIDTH        = 160;
  localparam int DEF_HEIGHT       = 120;
  localparam int DEF_REPEAT_DELAY = 4_000_000;
  localparam int DEF_REPEAT_RATE  = 1_000_000;
  localparam int DEF_MAX_BRUSH    = 4;

endpackage

// File: rtl/cursor_brush_ctrl_btn_repeat.sv
// Single-button edge detector with hold-to-repeat: one step on press, then
// a step after DELAY held cycles, then one every RATE cycles.
module btn_repeat #(
  parameter int DELAY = 8,
  parameter int RATE  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic step
);

  localparam int LONGEST = (DELAY > RATE) ? DELAY : RATE;
  localparam int CW      = $clog2(LONGEST + 1);
  localparam logic [CW-1:0] DELAY_LIM = CW'(DELAY - 1);
  localparam logic [CW-1:0] RATE_LIM  = CW'(RATE - 1);

  logic          btn_q;
  logic          repeating;
  logic [CW-1:0] cnt;

  // cnt counts cycles since the last step; the limit switches after the first repeat
  assign step = btn & (~btn_q | (cnt == (repeating ? RATE_LIM : DELAY_LIM)));

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q     <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
    end else begin
      btn_q <= btn;
      if (!btn) begin
        cnt       <= '0;
        repeating <= 1'b0;
      end else if (step) begin
        cnt       <= '0;
        repeating <= btn_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cursor_brush_ctrl.sv
// Cursor movement with button auto-repeat plus a square brush stamp engine
// writing to a framebuffer. Build option: CURSOR_WRAP_EN makes the cursor wrap at edges.
module cursor_brush_ctrl
  import cursor_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int HEIGHT       = DEF_HEIGHT,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int MAX_BRUSH    = DEF_MAX_BRUSH,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = $clog2(WIDTH * HEIGHT),
  localparam int SW = $clog2(MAX_BRUSH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          b_up,
  input  logic          b_down,
  input  logic          b_left,
  input  logic          b_right,
  input  logic [SW-1:0] brush_sel,
  input  logic [11:0]   colour_in,
  input  logic          draw_req,
  input  logic          wr_ready,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic [AW-1:0] cursor_addr,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [11:0]   wr_colour,
  output logic          busy,
  output logic          done
);

  localparam logic [XW-1:0] X_MAX     = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(HEIGHT - 1);
  localparam logic [XW:0]   X_LIM     = (XW + 1)'(WIDTH);
  localparam logic [YW:0]   Y_LIM     = (YW + 1)'(HEIGHT);
  localparam logic [SW:0]   BRUSH_LIM = (SW + 1)'(MAX_BRUSH);
  localparam logic [SW-1:0] SIZE_MAX  = SW'(MAX_BRUSH - 1);

  logic step_u, step_d, step_l, step_r;

  btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_rep_up    (.clk(clk), .reset(reset), .btn(b_up),    .step(step_u));
  btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_rep_down  (.clk(clk), .reset(reset), .btn(b_down),  .step(step_d));
  btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_rep_left  (.clk(clk), .reset(reset), .btn(b_left),  .step(step_l));
  btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_rep_right (.clk(clk), .reset(reset), .btn(b_right), .step(step_r));

  stamp_state_t  state, state_next;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;

  assign busy = (state == STAMP);

  // Opposing buttons cancel on level, so a held button blocks its opposite's steps
  always_comb begin
    next_x = cursor_x;
    next_y = cursor_y;
    if (!busy) begin
      if (step_r && !b_left) begin
`ifdef CURSOR_WRAP_EN
        next_x = (cursor_x == X_MAX) ? '0 : cursor_x + 1'b1;
`else
        next_x = (cursor_x == X_MAX) ? cursor_x : cursor_x + 1'b1;
`endif
      end else if (step_l && !b_right) begin
`ifdef CURSOR_WRAP_EN
        next_x = (cursor_x == '0) ? X_MAX : cursor_x - 1'b1;
`else
        next_x = (cursor_x == '0) ? cursor_x : cursor_x - 1'b1;
`endif
      end
      if (step_d && !b_up) begin
`ifdef CURSOR_WRAP_EN
        next_y = (cursor_y == Y_MAX) ? '0 : cursor_y + 1'b1;
`else
        next_y = (cursor_y == Y_MAX) ? cursor_y : cursor_y + 1'b1;
`endif
      end else if (step_u && !b_down) begin
`ifdef CURSOR_WRAP_EN
        next_y = (cursor_y == '0) ? Y_MAX : cursor_y - 1'b1;
`else
        next_y = (cursor_y == '0) ? cursor_y : cursor_y - 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cursor_x    <= XW'(WIDTH / 2);
      cursor_y    <= YW'(HEIGHT / 2);
      cursor_addr <= AW'((HEIGHT / 2) * WIDTH + WIDTH / 2);
    end else begin
      cursor_x    <= next_x;
      cursor_y    <= next_y;
      cursor_addr <= AW'(next_y) * AW'(WIDTH) + AW'(next_x);
    end
  end

  logic [XW-1:0] base_x;
  logic [YW-1:0] base_y;
  logic [AW-1:0] row_addr;
  colour_t       colour_q;
  logic [SW-1:0] size_q;
  logic [SW-1:0] dx, dy;
  logic          in_bounds, advance, last;

  assign in_bounds = (({1'b0, base_x} + (XW + 1)'(dx)) < X_LIM) &&
                     (({1'b0, base_y} + (YW + 1)'(dy)) < Y_LIM);
  assign advance   = busy && (!in_bounds || wr_ready);
  assign last      = (dx == size_q) && (dy == size_q);

  assign wr_valid  = busy && in_bounds;
  assign wr_addr   = wr_valid ? row_addr + AW'(dx) : '0;
  assign wr_colour = wr_valid ? colour_q : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (draw_req) state_next = STAMP;
      STAMP:   if (advance && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // row_addr tracks (base_y+dy)*WIDTH+base_x so no multiplier is needed per beat
  always_ff @(posedge clk) begin
    if (reset) begin
      base_x   <= '0;
      base_y   <= '0;
      row_addr <= '0;
      colour_q <= '0;
      size_q   <= '0;
      dx       <= '0;
      dy       <= '0;
      done     <= 1'b0;
    end else begin
      done <= advance && last;
      if (state == IDLE && draw_req) begin
        base_x   <= cursor_x;
        base_y   <= cursor_y;
        row_addr <= cursor_addr;
        colour_q <= colour_in;
        size_q   <= ({1'b0, brush_sel} >= BRUSH_LIM) ? SIZE_MAX : brush_sel;
        dx       <= '0;
        dy       <= '0;
      end else if (advance) begin
        if (dx == size_q) begin
          dx       <= '0;
          dy       <= dy + 1'b1;
          row_addr <= row_addr + AW'(WIDTH);
        end else begin
          dx <= dx + 1'b1;
        end
      end
    end
  end

endmodule
